hazard_ctrl: RTL

//  Pipeline interlock and forwarding scheduler for the 5-stage core. Shadows the
//  ID/EX/MEM/WB register-destination pipeline, drives the rs/rt forward selects and

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock, stall sequencing and EX-operand forwarding for the 5-stage core.
// Optional HI/LO occupancy tracking is built when HAZARD_MULDIV_EN is defined.
module hazard_ctrl #(
    parameter int MULDIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idValid,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRs,
    input  logic        idUsesRt,
    input  logic [4:0]  idDst,
    input  logic        idRegWrite,
    input  logic        idIsLoad,
    input  logic        idIsMulDiv,
    input  logic        idUsesHiLo,
    input  logic        flush,
    input  logic        memWait,
    input  logic [31:0] memAluResult,
    input  logic [31:0] wbWriteData,
    output logic        stall,
    output logic        freeze,
    output logic        rsFwd,
    output logic        rtFwd,
    output logic [31:0] rsFwdData,
    output logic [31:0] rtFwdData,
    output logic        mulDivBusy
);
    typedef enum logic [1:0] {RUN, LDSTALL, MDWAIT} state_e;
    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
    } ex_slot_t;
    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
    } mem_slot_t;
    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       wr;
    } wb_slot_t;

    localparam int CNT_W = $clog2(MULDIV_LAT + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MULDIV_LAT);

    state_e    state_q, state_d;
    ex_slot_t  ex_q, ex_d;
    mem_slot_t mem_q, mem_d;
    wb_slot_t  wb_q, wb_d;
    logic [1:0] rs_hit, rt_hit;
    logic ld_hazard, md_hazard, accept;

    assign freeze = memWait;
    assign accept = idValid & ~stall & ~flush;
    assign ld_hazard = ex_q.v & ex_q.ld & ex_q.wr & (ex_q.dst != 5'd0) & idValid &
                       ((idUsesRs & (idRs == ex_q.dst)) | (idUsesRt & (idRt == ex_q.dst)));

    // {MEM hit, WB hit}; a load sitting in MEM holds an address, never its data
    function automatic logic [1:0] hit(input logic [4:0] r);
        return {mem_q.v & mem_q.wr & ~mem_q.ld & (mem_q.dst == r) & (r != 5'd0),
                wb_q.v & wb_q.wr & (wb_q.dst == r) & (r != 5'd0)};
    endfunction

`ifdef HAZARD_MULDIV_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // HI/LO countdown: reload when a mul/div enters EX, count each unfrozen cycle
    always_comb begin
        cnt_d = cnt_q;
        if (!memWait)
            cnt_d = (accept & idIsMulDiv) ? LAT : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end

    // HI/LO occupancy counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign mulDivBusy = cnt_q != '0;
    assign md_hazard  = mulDivBusy & idValid & (idUsesHiLo | idIsMulDiv);
`else
    logic unused_md;
    assign unused_md  = ^{idIsMulDiv, idUsesHiLo, LAT};
    assign mulDivBusy = 1'b0;
    assign md_hazard  = 1'b0;
`endif

    // Slot advance: shift down the pipe unless frozen; stalled or flushed ID enters EX as a bubble
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!memWait) begin
            wb_d  = wb_slot_t'{mem_q.v, mem_q.dst, mem_q.wr};
            mem_d = mem_slot_t'{ex_q.v, ex_q.dst, ex_q.wr, ex_q.ld};
            ex_d  = accept ? ex_slot_t'{1'b1, idRs, idRt, idDst, idRegWrite, idIsLoad} : '0;
        end
    end

    // Destination shadow slots for EX/MEM/WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Operand forwarding for the instruction in EX, MEM has priority over WB
    always_comb begin
        rs_hit    = hit(ex_q.rs);
        rt_hit    = hit(ex_q.rt);
        rsFwd     = |rs_hit;
        rtFwd     = |rt_hit;
        rsFwdData = rs_hit[1] ? memAluResult : rs_hit[0] ? wbWriteData : '0;
        rtFwdData = rt_hit[1] ? memAluResult : rt_hit[0] ? wbWriteData : '0;
    end

    // Interlock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Interlock next state: frozen cycles hold, flush always returns to RUN
    always_comb begin
        state_d = state_q;
        if (!memWait) begin
            case (state_q)
                RUN:     state_d = ld_hazard ? LDSTALL : md_hazard ? MDWAIT : RUN;
                MDWAIT:  state_d = md_hazard ? MDWAIT : RUN;
                default: state_d = RUN;
            endcase
            if (flush) state_d = RUN;
        end
    end

    // Stall output: load-use only detected from RUN, HI/LO wait in every state
    always_comb begin
        stall = (state_q == RUN) ? (ld_hazard | md_hazard) : md_hazard;
    end
endmodule
